sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
Generalised synchronous FIFO with true power-of-two depth, a full-range occupancy counter and programmable almost-full/almost-empty thresholds. Supports both read modes: first-word-fall-through, and standard registered read. Simultaneous read/write is legal at every fill level, including full and empty. Rejected accesses are reported as overflow/underflow pulses. Drop-in buffer for stream datapaths between producer and consumer logic in one clock domain.

Parameters:
FIFO_WIDTH, 32, data word width in bits (>=1)
FIFO_DEPTH, 8, number of entries; power of two, >=2
FWFT, 1, 1 = first-word-fall-through read, 0 = standard registered read
AFULL_LEVEL, FIFO_DEPTH-2, almost_full asserts when count_out >= AFULL_LEVEL
AEMPTY_LEVEL, 2, almost_empty asserts when count_out <= AEMPTY_LEVEL
Derived: AW = $clog2(FIFO_DEPTH) (pointer width); CW = AW+1 (count width).
Legal parameters: 0 < AEMPTY_LEVEL < AFULL_LEVEL < FIFO_DEPTH. Any illegal set (including non-power-of-two depth) is an elaboration-time error.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
write_en  in  1  write request
din  in  FIFO_WIDTH  write data
read_en  in  1  read/pop request
dout  out  FIFO_WIDTH  read data
dout_valid  out  1  dout holds valid data
fifo_full  out  1  count_out == FIFO_DEPTH
fifo_empty  out  1  count_out == 0
almost_full  out  1  count_out >= AFULL_LEVEL
almost_empty  out  1  count_out <= AEMPTY_LEVEL
count_out  out  CW  stored words, 0..FIFO_DEPTH
overflow  out  1  one-cycle pulse: previous-cycle write was rejected
underflow  out  1  one-cycle pulse: previous-cycle read was rejected

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset is sampled at a clk edge and overrides read_en/write_en in the same cycle.
  - Reset clears: wr_ptr, rd_ptr, count_out, dout, dout_valid, overflow and underflow.
  - Resulting flags: fifo_empty=1, almost_empty=1, fifo_full=0, almost_full=0.
  - Storage array is not reset; its contents are don't-care.
- Acceptance rules, evaluated in the same cycle:
  - rd_acc = read_en & !fifo_empty
  - wr_acc = write_en & (!fifo_full | rd_acc)
- Full + read + write: both accepted; count is unchanged; the new word goes into the freed slot.
- Empty + read + write: read rejected (underflow next cycle), write accepted, count becomes 1.
- On wr_acc: mem[wr_ptr] <= din; wr_ptr increments mod FIFO_DEPTH (natural AW-bit wrap).
- On rd_acc: rd_ptr increments mod FIFO_DEPTH.
- count_out next = count_out + wr_acc - rd_acc, computed at CW bits. It never exceeds FIFO_DEPTH and never goes negative.
- All four status flags are combinational decodes of the registered count_out. Latency: a flag updates in the cycle after the causing edge.
- overflow <= write_en & !wr_acc. underflow <= read_en & !rd_acc. Each is registered, high for exactly one cycle per rejected request, and not sticky. A rejected access changes no state.
- FWFT=1 read mode:
  - dout = mem[rd_ptr] combinationally while !fifo_empty; dout = 0 while empty.
  - dout_valid = !fifo_empty.
  - read_en pops the word currently shown on dout.
  - A word written into an empty FIFO appears on dout the cycle after the write edge.
- FWFT=0 read mode:
  - On rd_acc, dout <= mem[rd_ptr] and dout_valid <= 1; data arrives 1 cycle after the read edge.
  - With no rd_acc, dout_valid <= 0 and dout holds its last value.
- Same-cycle read and write of the same slot (only possible at full): the read returns the old word and the write stores the new one.
- No bypass path: data written into an empty FIFO is never readable in the same cycle.

Test Plan:
WIDTH=8, DEPTH=4, AFULL=3, AEMPTY=1, FWFT=1 unless stated.
1. Reset, then write 0x11,0x22,0x33,0x44 on consecutive cycles -> count 1,2,3,4; almost_empty drops at count=2; almost_full rises at count=3; fifo_full at 4; dout=0x11 throughout; no overflow.
2. Full, write 0x55 alone -> overflow high exactly 1 cycle; count stays 4; subsequent reads return 0x11,0x22,0x33,0x44, then fifo_empty=1 and dout=0.
3. Full, read_en and write_en with din=0x66 in the same cycle -> count stays 4, no overflow; draining yields 0x22,0x33,0x44,0x66 (proves pointer wrap).
4. Empty, read_en and write_en with din=0x77 in the same cycle -> underflow pulse; count=1; dout=0x77 the next cycle.
5. FWFT=0, write 0xA1,0xB2 then read twice -> dout=0xA1 with dout_valid 1 cycle after the first read edge, then 0xB2; dout_valid=0 afterwards while dout holds 0xB2.
6. Reset asserted while count=3 together with write_en=1 -> next cycle count=0, fifo_empty=1, no overflow/underflow; the first later write reads back correctly.

Source files
------------

// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
// Single-clock FIFO with a power-of-two depth and a full-range occupancy count.
// The almost-full and almost-empty thresholds are parameters. The read mode is
// selectable:
//   - first-word-fall-through (FWFT=1)
//   - standard registered read (FWFT=0)
// A read and a write in the same cycle are legal at every fill level. When an
// access is rejected, overflow or underflow pulses high for one cycle on the
// following cycle.
//
// Parameters
//   FIFO_WIDTH   data word width (>=1)
//   FIFO_DEPTH   number of entries (power of two, >=2)
//   FWFT         1 = fall-through read, 0 = registered read
//   AFULL_LEVEL  almost_full  when count_out >= AFULL_LEVEL
//   AEMPTY_LEVEL almost_empty when count_out <= AEMPTY_LEVEL
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   write_en     write request, din is the data
//   read_en      read/pop request
//   dout         read data
//   dout_valid   dout holds valid data
//   fifo_full    count_out == FIFO_DEPTH
//   fifo_empty   count_out == 0
//   almost_full  count_out >= AFULL_LEVEL
//   almost_empty count_out <= AEMPTY_LEVEL
//   count_out    stored words, 0..FIFO_DEPTH
//   overflow     one-cycle pulse: previous-cycle write was rejected
//   underflow    one-cycle pulse: previous-cycle read was rejected
// -----------------------------------------------------------------------------
module sync_fifo_param #(
    parameter int FIFO_WIDTH   = 32,
    parameter int FIFO_DEPTH   = 8,
    parameter int FWFT         = 1,
    parameter int AFULL_LEVEL  = FIFO_DEPTH - 2,
    parameter int AEMPTY_LEVEL = 2,
    localparam int AW          = $clog2(FIFO_DEPTH),
    localparam int CW          = AW + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write_en,
    input  logic [FIFO_WIDTH-1:0] din,
    input  logic                  read_en,
    output logic [FIFO_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CW-1:0]         count_out,
    output logic                  overflow,
    output logic                  underflow
);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter legality
    // -------------------------------------------------------------------------
    if (FIFO_WIDTH < 1) begin : g_bad_width
        $error("sync_fifo_param: FIFO_WIDTH must be >= 1");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo_param: FIFO_DEPTH must be a power of two >= 2");
    end
    if (!(AEMPTY_LEVEL > 0 && AEMPTY_LEVEL < AFULL_LEVEL && AFULL_LEVEL < FIFO_DEPTH))
    begin : g_bad_levels
        $error("sync_fifo_param: need 0 < AEMPTY_LEVEL < AFULL_LEVEL < FIFO_DEPTH");
    end
    if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
        $error("sync_fifo_param: FWFT must be 0 or 1");
    end

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_rd_acc;
    logic                  w_wr_acc;
    logic [CW-1:0]         w_count_nxt;

    // -------------------------------------------------------------------------
    // Status decode from the registered count
    // -------------------------------------------------------------------------
    assign w_full       = (r_count == CW'(FIFO_DEPTH));
    assign w_empty      = (r_count == '0);

    assign fifo_full    = w_full;
    assign fifo_empty   = w_empty;
    assign almost_full  = (r_count >= CW'(AFULL_LEVEL));
    assign almost_empty = (r_count <= CW'(AEMPTY_LEVEL));
    assign count_out    = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    // -------------------------------------------------------------------------
    // Acceptance
    // -------------------------------------------------------------------------
    // A write into a full FIFO is accepted when a read frees a slot in the
    // same cycle. A read of an empty FIFO is never accepted, because no
    // write-to-read bypass exists.
    assign w_rd_acc    = read_en & ~w_empty;
    assign w_wr_acc    = write_en & (~w_full | w_rd_acc);
    assign w_count_nxt = r_count + CW'(w_wr_acc) - CW'(w_rd_acc);

    // -------------------------------------------------------------------------
    // Storage (not reset)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset && w_wr_acc) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // -------------------------------------------------------------------------
    // Pointers, count, reject pulses
    // -------------------------------------------------------------------------
    // The pointers are exactly AW bits wide, so the wrap modulo FIFO_DEPTH
    // falls out of the natural overflow of the add.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count     <= w_count_nxt;
            r_overflow  <= write_en & ~w_wr_acc;
            r_underflow <= read_en & ~w_rd_acc;
        end
    end

    // -------------------------------------------------------------------------
    // Read port
    // -------------------------------------------------------------------------
    if (FWFT != 0) begin : g_fwft
        // The head word is shown combinationally, and forced to zero while
        // the FIFO is empty so that stale storage never leaks out.
        assign dout       = w_empty ? '0 : r_mem[r_rd_ptr];
        assign dout_valid = ~w_empty;
    end else begin : g_std
        logic [FIFO_WIDTH-1:0] r_dout;
        logic                  r_dout_valid;

        // When the FIFO is full and is read and written in the same cycle,
        // both ports use the same slot. The non-blocking read captures the
        // old word before the write lands.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_dout       <= '0;
                r_dout_valid <= 1'b0;
            end else begin
                r_dout_valid <= w_rd_acc;
                if (w_rd_acc) begin
                    r_dout <= r_mem[r_rd_ptr];
                end
            end
        end

        assign dout       = r_dout;
        assign dout_valid = r_dout_valid;
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int AF = 3;
    localparam int AE = 1;
    localparam int CW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          write_en = 1'b0;
    logic          read_en = 1'b0;
    logic [W-1:0]  din = '0;

    // FWFT=1 instance outputs
    logic [W-1:0]  dout1;
    logic          dv1, full1, empty1, af1, ae1, ovf1, unf1;
    logic [CW-1:0] cnt1;
    // FWFT=0 instance outputs
    logic [W-1:0]  dout0;
    logic          dv0, full0, empty0, af0, ae0, ovf0, unf0;
    logic [CW-1:0] cnt0;

    always #5 clk = ~clk;

    sync_fifo_param #(
        .FIFO_WIDTH(W), .FIFO_DEPTH(D), .FWFT(1),
        .AFULL_LEVEL(AF), .AEMPTY_LEVEL(AE)
    ) dut_fwft (
        .clk(clk), .reset(reset), .write_en(write_en), .din(din),
        .read_en(read_en), .dout(dout1), .dout_valid(dv1),
        .fifo_full(full1), .fifo_empty(empty1), .almost_full(af1),
        .almost_empty(ae1), .count_out(cnt1), .overflow(ovf1), .underflow(unf1)
    );

    sync_fifo_param #(
        .FIFO_WIDTH(W), .FIFO_DEPTH(D), .FWFT(0),
        .AFULL_LEVEL(AF), .AEMPTY_LEVEL(AE)
    ) dut_std (
        .clk(clk), .reset(reset), .write_en(write_en), .din(din),
        .read_en(read_en), .dout(dout0), .dout_valid(dv0),
        .fifo_full(full0), .fifo_empty(empty0), .almost_full(af0),
        .almost_empty(ae0), .count_out(cnt0), .overflow(ovf0), .underflow(unf0)
    );

    // Reference model: the FIFO contents as a queue, plus the expected values
    // of the registered outputs
    logic [W-1:0] q[$];
    logic         exp_ovf = 1'b0;
    logic         exp_unf = 1'b0;
    logic [W-1:0] exp_dout0 = '0;
    logic         exp_dv0 = 1'b0;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all(input string ctx);
        int sz;
        sz = q.size();
        chk({ctx, ":count1"},  32'(cnt1),   32'(sz));
        chk({ctx, ":empty1"},  32'(empty1), 32'(sz == 0));
        chk({ctx, ":full1"},   32'(full1),  32'(sz == D));
        chk({ctx, ":afull1"},  32'(af1),    32'(sz >= AF));
        chk({ctx, ":aempty1"}, 32'(ae1),    32'(sz <= AE));
        chk({ctx, ":ovf1"},    32'(ovf1),   32'(exp_ovf));
        chk({ctx, ":unf1"},    32'(unf1),   32'(exp_unf));
        chk({ctx, ":dout1"},   32'(dout1),  (sz > 0) ? 32'(q[0]) : 32'h0);
        chk({ctx, ":dv1"},     32'(dv1),    32'(sz > 0));
        chk({ctx, ":count0"},  32'(cnt0),   32'(sz));
        chk({ctx, ":flags0"},  {28'h0, full0, empty0, af0, ae0},
            {28'h0, sz == D, sz == 0, sz >= AF, sz <= AE});
        chk({ctx, ":ovfunf0"}, {30'h0, ovf0, unf0}, {30'h0, exp_ovf, exp_unf});
        chk({ctx, ":dout0"},   32'(dout0),  32'(exp_dout0));
        chk({ctx, ":dv0"},     32'(dv0),    32'(exp_dv0));
    endtask

    // Drives one cycle of inputs, advances the model across the edge, and
    // checks every output 1 time unit after the edge.
    task automatic step(input logic we, input logic [W-1:0] d, input logic re,
                        input logic rst, input string ctx);
        logic rd_ok, wr_ok;
        write_en = we;
        din      = d;
        read_en  = re;
        reset    = rst;
        @(posedge clk);
        if (rst) begin
            q.delete();
            exp_ovf   = 1'b0;
            exp_unf   = 1'b0;
            exp_dout0 = '0;
            exp_dv0   = 1'b0;
        end else begin
            rd_ok   = re && (q.size() > 0);
            wr_ok   = we && ((q.size() < D) || rd_ok);
            exp_ovf = we && !wr_ok;
            exp_unf = re && !rd_ok;
            exp_dv0 = rd_ok;
            if (rd_ok) exp_dout0 = q.pop_front();
            if (wr_ok) q.push_back(d);
        end
        #1;
        check_all(ctx);
    endtask

    initial begin
        // 1: reset, then fill
        step(0, 8'h00, 0, 1, "rst");
        step(1, 8'h11, 0, 0, "w11");
        step(1, 8'h22, 0, 0, "w22");
        step(1, 8'h33, 0, 0, "w33");
        step(1, 8'h44, 0, 0, "w44");
        // 2: write while full, then drain
        step(1, 8'h55, 0, 0, "ovf");
        step(0, 8'h00, 0, 0, "ovf_gone");
        for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, "drain2");
        step(0, 8'h00, 0, 0, "empty2");
        // 3: simultaneous read and write at full, across the pointer wrap
        for (int i = 1; i <= 4; i++) step(1, 8'(i * 8'h11), 0, 0, "fill3");
        step(1, 8'h66, 1, 0, "rw_full");
        for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, "drain3");
        // 4: simultaneous read and write at empty
        step(1, 8'h77, 1, 0, "rw_empty");
        step(0, 8'h00, 0, 0, "after_rw_empty");
        step(0, 8'h00, 1, 0, "pop77");
        // 5: registered-read sequence (checked on dut_std)
        step(0, 8'h00, 0, 1, "rst5");
        step(1, 8'hA1, 0, 0, "wA1");
        step(1, 8'hB2, 0, 0, "wB2");
        step(0, 8'h00, 1, 0, "rA1");
        step(0, 8'h00, 1, 0, "rB2");
        step(0, 8'h00, 0, 0, "hold");
        chk("std_hold_dout", 32'(dout0), 32'hB2);
        chk("std_hold_dv",   32'(dv0),   32'h0);
        // 6: reset while holding 3 words, with write_en high
        for (int i = 0; i < 3; i++) step(1, 8'(8'hC0 + i), 0, 0, "fill6");
        step(1, 8'hEE, 0, 1, "rst_w");
        chk("rst_count", 32'(cnt1), 32'h0);
        step(1, 8'h5A, 0, 0, "w5A");
        step(0, 8'h00, 1, 0, "r5A");
        chk("rd_after_rst", 32'(dout0), 32'h5A);
        // Random traffic, with occasional resets
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 2) != 0), 8'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 49) == 0), "rand");
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
